// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//
// Shared ALU service block. Two requesters present (op, A, B) transactions
// over valid/ready. One is granted, the operation runs on the single ALU
// datapath, and a tagged 2W-bit result is returned over valid/ready. At most
// one transaction is in flight at a time.
//
// Operations (operands zero-extended to 2W bits):
//   000 ADD  A+B          100 XOR  A^B
//   001 SUB  A-B (wraps)  101 CAT  {A,B}
//   010 AND  A&B          110 MUL  A*B, shift-add, W cycles
//   011 OR   A|B          111 reserved, result 0
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   reqN_valid/op/a/b (N=0,1)     requester transaction
//   reqN_ready                    combinational accept strobe (IDLE only)
//   rsp_valid/rsp_id/rsp_result   registered response, held until rsp_ready
//   rsp_ready                     consumer accepts the response
//   busy                          registered, high whenever state != IDLE
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> req0 always wins a tie
//                          undefined -> round-robin on ties (req0 wins first)
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2*W-1:0]   rsp_result,
    output logic             busy
);

    localparam int RW = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_CAT = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Single-cycle operations. MUL is handled by the iterative path and the
    // reserved opcode yields zero, so both fall into the default arm.
    function automatic logic [RW-1:0] alu_single(
        input logic [2:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [RW-1:0] ax;
        logic [RW-1:0] bx;
        ax = {{W{1'b0}}, a};
        bx = {{W{1'b0}}, b};
        case (op)
            OP_ADD:  alu_single = ax + bx;
            OP_SUB:  alu_single = ax - bx;
            OP_AND:  alu_single = ax & bx;
            OP_OR:   alu_single = ax | bx;
            OP_XOR:  alu_single = ax ^ bx;
            OP_CAT:  alu_single = {a, b};
            default: alu_single = {RW{1'b0}};
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            id_q, id_d;
    logic            last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [RW-1:0]   rsp_result_q, rsp_result_d;
    logic            busy_q, busy_d;

    logic            any_valid_s;
    logic            grant_id_s;
    logic            accept_s;
    logic [2:0]      sel_op_s;
    logic [W-1:0]    sel_a_s;
    logic [W-1:0]    sel_b_s;
    logic [RW-1:0]   partial_s;
    logic [RW-1:0]   mul_sum_s;

    // Arbitration: a lone request always wins; a tie is settled by priority.
    always_comb begin
        any_valid_s = req0_valid | req1_valid;
        grant_id_s  = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant_id_s = 1'b0;
`else
            grant_id_s = ~last_grant_q;
`endif
        end else if (req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Accept strobes: only in IDLE and only toward the granted requester.
    always_comb begin
        accept_s   = (state_q == ST_IDLE) && any_valid_s;
        req0_ready = accept_s && !grant_id_s;
        req1_ready = accept_s && grant_id_s;
    end

    // Payload of the granted requester, sampled only on the accept edge.
    always_comb begin
        if (grant_id_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    // Shift-add step: add A<<cnt when bit cnt of B is set.
    always_comb begin
        if (b_q[cnt_q]) begin
            partial_s = {{W{1'b0}}, a_q} << cnt_q;
        end else begin
            partial_s = {RW{1'b0}};
        end
        mul_sum_s = acc_q + partial_s;
    end

    // Next-state and datapath update for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;

        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    op_d         = sel_op_s;
                    a_d          = sel_a_s;
                    b_d          = sel_b_s;
                    id_d         = grant_id_s;
                    last_grant_d = grant_id_s;
                    cnt_d        = CNT_ZERO;
                    acc_d        = {RW{1'b0}};
                    state_d      = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXEC: begin
                if (op_q == OP_MUL) begin
                    // The last partial product goes straight into the result
                    // register so the response appears W edges after accept.
                    if (cnt_q == CNT_LAST) begin
                        rsp_result_d = mul_sum_s;
                        rsp_id_d     = id_q;
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        acc_d   = mul_sum_s;
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = ST_EXEC;
                    end
                end else begin
                    rsp_result_d = alu_single(op_q, a_q, b_q);
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end
            end

            ST_RESP: begin
                // New requests wait for IDLE, so a handshake cycle never
                // overlaps an accept.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, operand and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= 3'd0;
            a_q          <= {W{1'b0}};
            b_q          <= {W{1'b0}};
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= CNT_ZERO;
            acc_q        <= {RW{1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= {RW{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_req_arbiter
//
// Self-checking bench for alu_req_arbiter. Each requester is fed from its own
// transaction queue. A cycle model predicts grants, busy and response timing;
// expected results are pushed to a scoreboard on accept and compared while
// the DUT presents the response.
// -----------------------------------------------------------------------------
module tb_alu_req_arbiter;

    localparam int W = 4;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } txn_t;

    typedef struct packed {
        logic           id;
        logic [2*W-1:0] res;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req0_valid, req0_ready;
    logic [2:0]     req0_op;
    logic [W-1:0]   req0_a, req0_b;
    logic           req1_valid, req1_ready;
    logic [2:0]     req1_op;
    logic [W-1:0]   req1_a, req1_b;
    logic           rsp_valid, rsp_ready, rsp_id, busy;
    logic [2*W-1:0] rsp_result;

    txn_t q0[$];
    txn_t q1[$];
    exp_t sb[$];
    int   id_log[$];

    int   n_tests = 0;
    int   n_fail  = 0;

    // Cycle model: 0 idle, 1 exec, 2 resp.
    int   m_st   = 0;
    int   m_cnt  = 0;
    logic m_last = 1'b1;

    always #5 clk = ~clk;

    alu_req_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_alu(input txn_t t);
        logic [2*W-1:0] ax;
        logic [2*W-1:0] bx;
        ax = {{W{1'b0}}, t.a};
        bx = {{W{1'b0}}, t.b};
        case (t.op)
            3'd0:    return ax + bx;
            3'd1:    return ax - bx;
            3'd2:    return ax & bx;
            3'd3:    return ax | bx;
            3'd4:    return ax ^ bx;
            3'd5:    return {t.a, t.b};
            3'd6:    return ax * bx;
            default: return '0;
        endcase
    endfunction

    function automatic txn_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        txn_t t;
        t.op = op;
        t.a  = a;
        t.b  = b;
        return t;
    endfunction

    task automatic drive();
        if (q0.size() > 0) begin
            req0_valid = 1'b1;
            {req0_op, req0_a, req0_b} = q0[0];
        end else begin
            req0_valid = 1'b0;
            {req0_op, req0_a, req0_b} = '0;
        end
        if (q1.size() > 0) begin
            req1_valid = 1'b1;
            {req1_op, req1_a, req1_b} = q1[0];
        end else begin
            req1_valid = 1'b0;
            {req1_op, req1_a, req1_b} = '0;
        end
    endtask

    // One clock cycle: drive at negedge, check, then advance the model at posedge.
    task automatic tick();
        logic v0, v1, gnt, gid;
        txn_t t;
        exp_t e;
        drive();
        #1;
        v0  = (q0.size() > 0);
        v1  = (q1.size() > 0);
        gnt = (m_st == 0) && (v0 || v1);
        if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            gid = 1'b0;
`else
            gid = ~m_last;
`endif
        end else begin
            gid = v1;
        end
        check_eq("req0_ready", 16'(req0_ready), 16'(gnt && !gid));
        check_eq("req1_ready", 16'(req1_ready), 16'(gnt && gid));
        check_eq("busy", 16'(busy), 16'(m_st != 0));
        check_eq("rsp_valid", 16'(rsp_valid), 16'(m_st == 2));
        if (m_st == 2) begin
            check_eq("sb_nonempty", 16'(sb.size() > 0), 16'd1);
            if (sb.size() > 0) begin
                check_eq("rsp_id", 16'(rsp_id), 16'(sb[0].id));
                check_eq("rsp_result", 16'(rsp_result), 16'(sb[0].res));
            end
            if (rsp_ready) id_log.push_back(int'(rsp_id));
        end
        @(posedge clk);
        case (m_st)
            0: begin
                if (gnt) begin
                    if (gid) t = q1.pop_front();
                    else     t = q0.pop_front();
                    e.id  = gid;
                    e.res = ref_alu(t);
                    sb.push_back(e);
                    m_last = gid;
                    m_cnt  = (t.op == 3'd6) ? W : 1;
                    m_st   = 1;
                end
            end
            1: begin
                m_cnt--;
                if (m_cnt == 0) m_st = 2;
            end
            2: begin
                if (rsp_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    m_st = 0;
                end
            end
            default: m_st = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_st != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq("drain_timeout", 16'(n >= max_cyc), 16'd0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check_eq("rst_busy", 16'(busy), 16'd0);
        check_eq("rst_rsp_id", 16'(rsp_id), 16'd0);
        check_eq("rst_rsp_result", 16'(rsp_result), 16'd0);
        q0.delete();
        q1.delete();
        sb.delete();
        m_st   = 0;
        m_cnt  = 0;
        m_last = 1'b1;
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        drive();
        @(negedge clk);
        do_reset();

        // Test 1: single ADD from req0.
        q0.push_back(mk(3'd0, 4'd9, 4'd8));
        drain(50);

        // Test 2: SUB then CAT from req1.
        q1.push_back(mk(3'd1, 4'd3, 4'd5));
        q1.push_back(mk(3'd5, 4'hA, 4'h5));
        drain(50);

        // Test 3: multi-cycle multiply, including a zero operand.
        q0.push_back(mk(3'd6, 4'hF, 4'hF));
        q0.push_back(mk(3'd6, 4'h0, 4'h7));
        q1.push_back(mk(3'd6, 4'h5, 4'hB));
        q1.push_back(mk(3'd7, 4'h5, 4'hB));
        drain(100);

        // Test 4: both requesters continuously valid.
        do_reset();
        id_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(3'd0, 4'd1, 4'd1));
            q1.push_back(mk(3'd0, 4'd2, 4'd2));
        end
        drain(200);
        check_eq("t4_count", 16'(id_log.size()), 16'd8);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            check_eq($sformatf("t4_grant%0d", i), 16'(id_log[i]), 16'd0);
`else
            check_eq($sformatf("t4_grant%0d", i), 16'(id_log[i]), 16'(i % 2));
`endif
        end

        // Test 5: backpressure while req1 waits.
        do_reset();
        rsp_ready = 1'b0;
        q0.push_back(mk(3'd4, 4'hC, 4'hA));
        q1.push_back(mk(3'd2, 4'hE, 4'h7));
        for (int i = 0; i < 20 && m_st != 2; i++) tick();
        check_eq("t5_reach_resp", 16'(m_st == 2), 16'd1);
        for (int i = 0; i < 5; i++) tick();
        rsp_ready = 1'b1;
        drain(50);

        // Test 6: reset during a multiply.
        do_reset();
        q0.push_back(mk(3'd6, 4'hF, 4'hF));
        tick();
        tick();
        tick();
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        id_log.delete();
        q0.push_back(mk(3'd0, 4'd1, 4'd1));
        q1.push_back(mk(3'd0, 4'd2, 4'd2));
        drain(50);
        check_eq("t6_count", 16'(id_log.size()), 16'd2);
        check_eq("t6_first_tie", 16'(id_log[0]), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shared 4-bit ALU service block: two requesters submit (op, A, B) transactions over valid/ready, and the block arbitrates between them. It executes the op (single-cycle logic/arith, concatenation, multi-cycle shift-add multiply) and returns a tagged 2W-bit result over valid/ready. It sits between the operand sources and the result consumer, and owns the only ALU datapath instance.

Parameters:
W, 4, operand width in bits; result width is 2*W.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a transaction
req0_ready  output  1  requester 0 transaction accepted this cycle
req0_op  input  3  requester 0 opcode
req0_a  input  W  requester 0 operand A
req0_b  input  W  requester 0 operand B
req1_valid  input  1  requester 1 has a transaction
req1_ready  output  1  requester 1 transaction accepted this cycle
req1_op  input  3  requester 1 opcode
req1_a  input  W  requester 1 operand A
req1_b  input  W  requester 1 operand B
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_id  output  1  requester that issued the result (0/1)
rsp_result  output  2W  result
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE; rsp_valid=0; rsp_id=0; rsp_result=0; busy=0; last_grant=1 (req0 wins the first tie); operand/count registers=0. In-flight op is discarded and no response is produced.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: if any reqN_valid, grant one requester. reqN_ready is combinational: high only in IDLE and only for the granted requester; the other ready stays 0. Latch op/a/b/id, update last_grant, and go to EXEC. With no valid, stay in IDLE.
- Arbitration: round-robin. If both are valid, grant !last_grant. A single valid request is always granted.
- Opcodes, with operands zero-extended to 2W:
  - 000 ADD: A+B.
  - 001 SUB: (A-B) mod 2^(2W).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 CAT: {A,B}.
  - 110 MUL: A*B by shift-add, one bit of B per cycle.
  - 111: reserved; result 0.
- EXEC, non-MUL: 1 cycle. The result is registered at the end of the cycle, then go to RESP. Accept edge k gives rsp_valid high from edge k+1.
- EXEC, MUL: exactly W cycles, with the counter counting 0..W-1 and one partial-product add per cycle. Accept edge k gives rsp_valid from edge k+W.
- RESP: rsp_valid=1, and rsp_result/rsp_id are held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE with rsp_valid=0 the next cycle. A new request is accepted no earlier than the cycle after the response handshake (max 1 transaction in flight).
- Requests arriving while busy are not accepted (ready=0). Requesters must hold valid and payload until ready.
- Payload sampling: taken only on the accept edge. Input changes afterwards do not affect the result.
- Simultaneous rsp handshake and new valids: the new valids are ignored that cycle and arbitrated in IDLE next cycle using the updated last_grant.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN
- Defined: fixed priority; req0 always wins when both are valid, and last_grant is ignored.
- Undefined: round-robin as described above.
- All other timing is identical in both cases.

Test Plan:
1. Reset, then req0 ADD A=9 B=8 -> req0_ready pulses 1 cycle; rsp_valid 1 cycle after accept; rsp_result=0x11, rsp_id=0; busy high from accept to response handshake.
2. req1 SUB A=3 B=5, then CAT A=0xA B=0x5 -> results 0xFE then 0xA5, rsp_id=1 for both.
3. req0 MUL A=0xF B=0xF -> rsp_valid exactly 4 cycles after accept; rsp_result=0xE1. Also check that 0x0*0x7 gives 0x00.
4. Both valid continuously with ADD (req0 A=1 B=1, req1 A=2 B=2), rsp_ready=1 -> grants alternate 0,1,0,1; results alternate 0x02/0x04. With ALU_ARB_FIXED_PRIO_EN, all grants go to req0.
5. Backpressure: XOR A=0xC B=0xA with rsp_ready=0 for 5 cycles -> rsp_valid/result=0x06 held stable; req1_valid high throughout is not accepted until the cycle after the handshake.
6. rst_n low mid-MUL (cycle 2 of 4) -> rsp_valid=0, busy=0 immediately. After release, no stale response appears, and the first tie goes to req0.
